hps_cmd_seq: RTL and testbench

HPS-side command sequencer that drives the `hps_cmd` input of the run-control unit. It turns single-cycle start/stop requests from the HPS register bridge into a correctly shaped `hps_cmd` pulse, then tracks the control unit's `state` until the requested transition completes. It reports completion and error status back to the bridge. It sits directly upstream of the control unit; its `hps_cmd` output connects one-to-one to the control unit's `hps_cmd` input.

---
 rtl/hps_cmd_seq.sv | 133 +++++++++++++
 tb/tb_hps_cmd_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hps_cmd_seq.sv
// rtl/hps_cmd_seq.sv - HPS start/stop command sequencer driving the run-control unit hps_cmd input
// Optional RELEASE timeout (err_code 11) is compiled in when HPS_CMD_SEQ_TIMEOUT_EN is defined.
module hps_cmd_seq #(
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_start,
  input  logic       req_stop,
  input  logic [1:0] ctrl_state,
  output logic       hps_cmd,
  output logic       busy,
  output logic       done,
  output logic [1:0] err_code
);

  localparam logic [1:0] CU_STOPPED  = 2'b00;
  localparam logic [1:0] CU_STARTING = 2'b01;
  localparam logic [1:0] CU_STOPPING = 2'b10;
  localparam logic [1:0] CU_STARTED  = 2'b11;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_STATE   = 2'b10;

  localparam int PW = $clog2(PULSE_CYCLES + 1);

  // A pulse shorter than two cycles is not seen reliably by the control unit.
  if (PULSE_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("hps_cmd_seq: PULSE_CYCLES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_RELEASE,
    ST_FINISH
  } state_t;

  state_t          state;
  logic [PW-1:0]   pulse_cnt;
  logic [1:0]      mid_state;
  logic [1:0]      tgt_state;
  logic            start_ok;
  logic            stop_ok;
  logic            stable;

`ifdef HPS_CMD_SEQ_TIMEOUT_EN
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]   to_cnt;
`endif

  // Only one request at a time may be accepted, and only from the matching stable state.
  assign start_ok = req_start && !req_stop && (ctrl_state == CU_STOPPED);
  assign stop_ok  = req_stop && !req_start && (ctrl_state == CU_STARTED);
  assign stable   = (ctrl_state == CU_STOPPED) || (ctrl_state == CU_STARTED);

  // Sequencer FSM with registered hps_cmd/busy/done/err_code.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      hps_cmd   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_code  <= ERR_OK;
      pulse_cnt <= '0;
      mid_state <= CU_STOPPED;
      tgt_state <= CU_STOPPED;
`ifdef HPS_CMD_SEQ_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok || stop_ok) begin
            mid_state <= start_ok ? CU_STARTING : CU_STOPPING;
            tgt_state <= start_ok ? CU_STARTED  : CU_STOPPED;
            err_code  <= ERR_OK;
            hps_cmd   <= 1'b1;
            busy      <= 1'b1;
            pulse_cnt <= '0;
            state     <= ST_ASSERT;
          end else if (req_start || req_stop) begin
            // Rejections still pass through FINISH so done stays a single pulse.
            err_code <= ERR_ILLEGAL;
            done     <= 1'b1;
            state    <= ST_FINISH;
          end
        end
        ST_ASSERT: begin
          if (pulse_cnt == PW'(PULSE_CYCLES - 1)) begin
            // A halt racing the command leaves the unit outside the expected intermediate state.
            if (ctrl_state != mid_state) err_code <= ERR_STATE;
            hps_cmd <= 1'b0;
            state   <= ST_RELEASE;
`ifdef HPS_CMD_SEQ_TIMEOUT_EN
            to_cnt  <= '0;
`endif
          end else begin
            pulse_cnt <= pulse_cnt + PW'(1);
          end
        end
        ST_RELEASE: begin
          if ((ctrl_state == tgt_state) || ((err_code == ERR_STATE) && stable)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_FINISH;
          end
`ifdef HPS_CMD_SEQ_TIMEOUT_EN
          else if (to_cnt == TW'(TIMEOUT_CYCLES)) begin
            err_code <= ERR_TIMEOUT;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= ST_FINISH;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
`endif
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hps_cmd_seq.sv
// tb/tb_hps_cmd_seq.sv - self-checking bench for hps_cmd_seq with a behavioural control unit model
module tb_hps_cmd_seq;

  localparam int P = 4;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_start;
  logic       req_stop;
  logic [1:0] ctrl_state;
  logic       hps_cmd;
  logic       busy;
  logic       done;
  logic [1:0] err_code;

  // Control unit model: hps_cmd high moves a stable state to its intermediate state,
  // hps_cmd low moves an intermediate state on to the opposite stable state.
  logic [1:0] cu_state = 2'b00;
  logic       cu_load;
  logic [1:0] cu_load_val;
  logic       cu_halt;
  logic       cu_freeze;

  assign ctrl_state = cu_state;

  hps_cmd_seq #(
    .PULSE_CYCLES   (P),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_start  (req_start),
    .req_stop   (req_stop),
    .ctrl_state (ctrl_state),
    .hps_cmd    (hps_cmd),
    .busy       (busy),
    .done       (done),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cu_load) cu_state <= cu_load_val;
    else if (cu_halt) cu_state <= 2'b00;
    else if (!cu_freeze) begin
      case (cu_state)
        2'b00: if (hps_cmd)  cu_state <= 2'b01;
        2'b11: if (hps_cmd)  cu_state <= 2'b10;
        2'b01: if (!hps_cmd) cu_state <= 2'b11;
        default: if (!hps_cmd) cu_state <= 2'b00;
      endcase
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_cu(input logic [1:0] v);
    cu_load = 1'b1;
    cu_load_val = v;
    tick();
    cu_load = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_start = 1'b0;
    req_stop = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  typedef struct {
    logic       rs;
    logic       rp;
    logic [1:0] cu0;
    int         done_cyc;
    logic [1:0] err;
    logic       acc;
    logic [1:0] cu_end;
  } vec_t;

  vec_t vecs [8];

  int         first_done;
  logic [1:0] err_at_done;
  int         kind;
  int         t;
  logic [1:0] err_m;
  int         r;
  logic       rs;
  logic       rp;
  logic       can_acc;

  initial begin
    cu_load = 1'b0; cu_load_val = 2'b00; cu_halt = 1'b0; cu_freeze = 1'b0;
    reset_n = 1'b0; req_start = 1'b0; req_stop = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 2'b00, P + 3, 2'b00, 1'b1, 2'b11};
    vecs[1] = '{1'b0, 1'b1, 2'b11, P + 3, 2'b00, 1'b1, 2'b00};
    vecs[2] = '{1'b1, 1'b0, 2'b11, 1,     2'b01, 1'b0, 2'b11};
    vecs[3] = '{1'b1, 1'b1, 2'b00, 1,     2'b01, 1'b0, 2'b00};
    vecs[4] = '{1'b0, 1'b1, 2'b00, 1,     2'b01, 1'b0, 2'b00};
    vecs[5] = '{1'b1, 1'b1, 2'b11, 1,     2'b01, 1'b0, 2'b11};
    vecs[6] = '{1'b0, 1'b1, 2'b01, 1,     2'b01, 1'b0, 2'b11};
    vecs[7] = '{1'b1, 1'b0, 2'b10, 1,     2'b01, 1'b0, 2'b00};

    // Reset values, sampled while reset is held.
    reset_n = 1'b0;
    repeat (3) tick();
    check("rst_hps", hps_cmd, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err_code, 2'b00);
    reset_n = 1'b1;
    tick();

    // Table-driven single requests.
    for (int v = 0; v < 8; v++) begin
      load_cu(vecs[v].cu0);
      req_start = vecs[v].rs;
      req_stop = vecs[v].rp;
      for (int c = 1; c <= 12; c++) begin
        tick();
        req_start = 1'b0;
        req_stop = 1'b0;
        check($sformatf("tbl%0d_c%0d_hps", v, c), hps_cmd, vecs[v].acc && (c <= P));
        check($sformatf("tbl%0d_c%0d_busy", v, c), busy, vecs[v].acc && (c <= P + 2));
        check($sformatf("tbl%0d_c%0d_done", v, c), done, c == vecs[v].done_cyc);
        if (vecs[v].acc && c == P + 2)
          check($sformatf("tbl%0d_cu_target", v), ctrl_state, vecs[v].cu_end);
      end
      check($sformatf("tbl%0d_err", v), err_code, vecs[v].err);
      check($sformatf("tbl%0d_cu_end", v), ctrl_state, vecs[v].cu_end);
    end

    // Halt race: stop accepted, then the unit is forced to STOPPED from cycle 1.
    load_cu(2'b11);
    req_stop = 1'b1;
    cu_halt = 1'b1;
    first_done = 0;
    err_at_done = 2'b00;
    for (int c = 1; c <= 20; c++) begin
      tick();
      req_stop = 1'b0;
      if (done && first_done == 0) begin
        first_done = c;
        err_at_done = err_code;
      end
    end
    cu_halt = 1'b0;
    check("halt_done_cycle", first_done, P + 2);
    check("halt_err", err_at_done, 2'b10);
    check("halt_busy_end", busy, 1'b0);

    // Control unit frozen in STARTING after a start request.
    load_cu(2'b00);
    req_start = 1'b1;
    first_done = 0;
    err_at_done = 2'b00;
    for (int c = 1; c <= 60; c++) begin
      tick();
      req_start = 1'b0;
      if (c == 2) begin
        check("frz_cu_starting", ctrl_state, 2'b01);
        cu_freeze = 1'b1;
      end
      if (done && first_done == 0) begin
        first_done = c;
        err_at_done = err_code;
      end
    end
`ifdef HPS_CMD_SEQ_TIMEOUT_EN
    check("tmo_done_cycle", first_done, P + T + 2);
    check("tmo_err", err_at_done, 2'b11);
`else
    check("frz_no_done", first_done, 0);
    check("frz_still_busy", busy, 1'b1);
    check("frz_err", err_code, 2'b00);
`endif
    cu_freeze = 1'b0;
    first_done = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (done && first_done == 0) first_done = c;
    end
`ifdef HPS_CMD_SEQ_TIMEOUT_EN
    check("tmo_no_late_done", first_done, 0);
    check("tmo_err_held", err_code, 2'b11);
`else
    check("frz_release_done", first_done != 0, 1'b1);
    check("frz_release_err", err_code, 2'b00);
`endif
    check("frz_busy_end", busy, 1'b0);
    check("frz_cu_end", ctrl_state, 2'b11);

    // Reset in the middle of ASSERT; unit left stuck in STARTING.
    load_cu(2'b00);
    req_start = 1'b1;
    tick();
    req_start = 1'b0;
    tick();
    reset_n = 1'b0;
    cu_freeze = 1'b1;
    tick();
    check("mrst_hps", hps_cmd, 1'b0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_done", done, 1'b0);
    check("mrst_err", err_code, 2'b00);
    check("mrst_cu_left", ctrl_state, 2'b01);
    reset_n = 1'b1;
    tick();
    req_start = 1'b1;
    tick();
    req_start = 1'b0;
    check("mrst_rej_done", done, 1'b1);
    check("mrst_rej_err", err_code, 2'b01);
    check("mrst_rej_hps", hps_cmd, 1'b0);
    check("mrst_rej_busy", busy, 1'b0);
    cu_freeze = 1'b0;
    repeat (3) tick();

    // Requests while busy and during FINISH are dropped.
    check("drop_cu_start", ctrl_state, 2'b11);
    req_stop = 1'b1;
    for (int c = 1; c <= P + 8; c++) begin
      tick();
      req_start = 1'b0;
      req_stop = 1'b0;
      check($sformatf("drop_c%0d_hps", c), hps_cmd, c <= P);
      check($sformatf("drop_c%0d_busy", c), busy, c <= P + 2);
      check($sformatf("drop_c%0d_done", c), done, c == P + 3);
      if (c == 2) req_stop = 1'b1;
      if (c == P + 3) req_start = 1'b1;
    end
    check("drop_err", err_code, 2'b00);
    check("drop_cu_end", ctrl_state, 2'b00);

    // Randomized requests against a timing-table reference model.
    do_reset();
    load_cu(2'b00);
    kind = 0;
    t = 0;
    err_m = 2'b00;
    for (int i = 0; i < 2000; i++) begin
      tick();
      req_start = 1'b0;
      req_stop = 1'b0;
      cu_load = 1'b0;
      if (t < 100000) t++;
      if (kind != 0 && t == 1) err_m = (kind == 1) ? 2'b00 : 2'b01;
      check("rnd_hps", hps_cmd, (kind == 1) && (t >= 1) && (t <= P));
      check("rnd_busy", busy, (kind == 1) && (t >= 1) && (t <= P + 2));
      check("rnd_done", done, ((kind == 1) && (t == P + 3)) || ((kind == 2) && (t == 1)));
      check("rnd_err", err_code, err_m);
      can_acc = (kind == 0) || ((kind == 1) && (t >= P + 4)) || ((kind == 2) && (t >= 2));
      r = int'($urandom_range(0, 7));
      rs = 1'b0;
      rp = 1'b0;
      case (r)
        2: rs = 1'b1;
        3: rp = 1'b1;
        4: begin rs = 1'b1; rp = 1'b1; end
        5, 6: begin
          if (cu_state == 2'b11) rp = 1'b1;
          else rs = 1'b1;
        end
        7: if (can_acc) begin
          cu_load = 1'b1;
          cu_load_val = 2'($urandom_range(0, 3));
        end
        default: ;
      endcase
      req_start = rs;
      req_stop = rp;
      if ((rs || rp) && can_acc) begin
        kind = ((rs ^ rp) && ((rs && cu_state == 2'b00) || (rp && cu_state == 2'b11))) ? 1 : 2;
        t = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
